// File: rtl/bip_control.sv
// Fetch/execute sequencer and opcode decoder for the 16-bit accumulator CPU; 2 cycles per instruction.
// Decode strobes are combinational in EXECUTE only; i_enable low pauses at the next instruction boundary.
module bip_control #(
  parameter int NBITS_O  = 11,
  parameter int NBITS_D  = 16,
  parameter int NBITS_OP = 5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  output logic [NBITS_O-1:0]  o_Addr,
  input  logic [NBITS_D-1:0]  i_Data,
  output logic [NBITS_O-1:0]  o_Operand,
  output logic                o_RdRam,
  output logic                o_WrRam,
  output logic                o_WrAcc,
  output logic [1:0]          o_SelA,
  output logic                o_SelB,
  output logic                o_Op,
  output logic                o_halt,
  output logic [15:0]         o_instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [NBITS_OP-1:0] OP_HLT  = NBITS_OP'(0);
  localparam logic [NBITS_OP-1:0] OP_STO  = NBITS_OP'(1);
  localparam logic [NBITS_OP-1:0] OP_LD   = NBITS_OP'(2);
  localparam logic [NBITS_OP-1:0] OP_LDI  = NBITS_OP'(3);
  localparam logic [NBITS_OP-1:0] OP_ADD  = NBITS_OP'(4);
  localparam logic [NBITS_OP-1:0] OP_ADDI = NBITS_OP'(5);
  localparam logic [NBITS_OP-1:0] OP_SUB  = NBITS_OP'(6);
  localparam logic [NBITS_OP-1:0] OP_SUBI = NBITS_OP'(7);

  state_t               state_q, state_d;
  logic [NBITS_O-1:0]   pc_q, pc_d;
  logic [NBITS_D-1:0]   ir_q, ir_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NBITS_OP-1:0]  opcode;

  assign opcode        = ir_q[NBITS_D-1 -: NBITS_OP];
  assign o_Addr        = pc_q;
  assign o_Operand     = ir_q[NBITS_O-1:0];
  assign o_instr_count = cnt_q;
  assign o_halt        = (state_q == S_HALT);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    o_RdRam = 1'b0;
    o_WrRam = 1'b0;
    o_WrAcc = 1'b0;
    o_SelA  = 2'b00;
    o_SelB  = 1'b0;
    o_Op    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = i_Data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_STO:  o_WrRam = 1'b1;
          OP_LD:   begin o_RdRam = 1'b1; o_WrAcc = 1'b1; end
          OP_LDI:  begin o_WrAcc = 1'b1; o_SelA = 2'b01; end
          OP_ADD:  begin o_RdRam = 1'b1; o_WrAcc = 1'b1; o_SelA = 2'b10; end
          OP_ADDI: begin o_WrAcc = 1'b1; o_SelA = 2'b10; o_SelB = 1'b1; end
          OP_SUB:  begin o_RdRam = 1'b1; o_WrAcc = 1'b1; o_SelA = 2'b10; o_Op = 1'b1; end
          OP_SUBI: begin o_WrAcc = 1'b1; o_SelA = 2'b10; o_SelB = 1'b1; o_Op = 1'b1; end
          default: ;
        endcase
        // HLT freezes PC on itself so the debug unit sees where execution stopped.
        if (opcode == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + NBITS_O'(1);
          cnt_d   = cnt_q + 16'd1;
          state_d = i_enable ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: an instruction-level model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [10:0] o_Addr;
  logic [15:0] i_Data;
  logic [10:0] o_Operand;
  logic        o_RdRam, o_WrRam, o_WrAcc, o_SelB, o_Op, o_halt;
  logic [1:0]  o_SelA;
  logic [15:0] o_instr_count;

  logic [15:0] mem [0:2047];
  assign i_Data = mem[o_Addr];

  always #5 clk = ~clk;

  bip_control #(.NBITS_O(11), .NBITS_D(16), .NBITS_OP(5)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .o_Addr        (o_Addr),
    .i_Data        (i_Data),
    .o_Operand     (o_Operand),
    .o_RdRam       (o_RdRam),
    .o_WrRam       (o_WrRam),
    .o_WrAcc       (o_WrAcc),
    .o_SelA        (o_SelA),
    .o_SelB        (o_SelB),
    .o_Op          (o_Op),
    .o_halt        (o_halt),
    .o_instr_count (o_instr_count)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [10:0] operand;
    logic [6:0]  ctrl;     // {rd, wr, wacc, sela[1:0], selb, op}
    logic        halt;
    logic [15:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Expected controls per opcode, straight from the decode table; unlisted entries stay 0.
  logic [6:0] ctrl_tbl [0:31];

  // Model: phase 0 idle, 1 about to fetch, 2 executing, 3 halted.
  int          m_phase;
  int          m_pc;
  int          m_cnt;
  logic [15:0] m_ir;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.addr    = 11'(m_pc);
    s.operand = m_ir[10:0];
    s.ctrl    = (m_phase == 2) ? ctrl_tbl[m_ir[15:11]] : 7'd0;
    s.halt    = (m_phase == 3);
    s.cnt     = 16'(m_cnt);
    return s;
  endfunction

  task automatic model_advance(input logic en);
    case (m_phase)
      0: if (en) m_phase = 1;
      1: begin m_ir = mem[m_pc]; m_phase = 2; end
      2: begin
        if (m_ir[15:11] == 5'd0) begin
          m_phase = 3;
        end else begin
          m_pc    = (m_pc + 1) % 2048;
          m_cnt   = (m_cnt + 1) % 65536;
          m_phase = en ? 1 : 0;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: apply inputs, predict outputs visible before the next edge, then take the edge.
  task automatic cycle(input logic rst, input logic en);
    i_reset  = rst;
    i_enable = en;
    if (!rst) begin
      m_phase = 0; m_pc = 0; m_cnt = 0; m_ir = 16'h0000;
    end
    exp_q.push_back(model_snap());
    if (rst) model_advance(en);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  function automatic logic [15:0] rand_nonhalt();
    logic [4:0]  opc;
    logic [10:0] opnd;
    opc  = 5'($urandom_range(1, 31));
    opnd = 11'($urandom);
    return {opc, opnd};
  endfunction

  initial begin : monitor
    snap_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {o_Addr, o_Operand, {o_RdRam, o_WrRam, o_WrAcc, o_SelA, o_SelB, o_Op}, o_halt, o_instr_count};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL cycle_outputs @%0t: got addr=%h opnd=%h ctrl=%b halt=%b cnt=%0d, expected addr=%h opnd=%h ctrl=%b halt=%b cnt=%0d",
                   $time, a.addr, a.operand, a.ctrl, a.halt, a.cnt, e.addr, e.operand, e.ctrl, e.halt, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 32; i++) ctrl_tbl[i] = 7'd0;
    ctrl_tbl[1] = 7'b0100000;  // STO
    ctrl_tbl[2] = 7'b1010000;  // LD
    ctrl_tbl[3] = 7'b0010100;  // LDI
    ctrl_tbl[4] = 7'b1011000;  // ADD
    ctrl_tbl[5] = 7'b0011010;  // ADDI
    ctrl_tbl[6] = 7'b1011001;  // SUB
    ctrl_tbl[7] = 7'b0011011;  // SUBI
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    m_phase = 0; m_pc = 0; m_cnt = 0; m_ir = 16'h0000;
    i_reset  = 1'b0;
    i_enable = 1'b0;
    @(posedge clk);
    #1;

    // Program LDI 8, ADDI 2, STO 7, HLT; then enable toggling while halted.
    mem[0] = {5'd3, 11'h008};
    mem[1] = {5'd5, 11'h002};
    mem[2] = {5'd1, 11'h007};
    mem[3] = {5'd0, 11'h000};
    do_reset();
    check("reset_addr", 32'(o_Addr), 32'd0);
    check("reset_count", 32'(o_instr_count), 32'd0);
    check("reset_halt", 32'(o_halt), 32'd0);
    repeat (12) cycle(1'b1, 1'b1);
    check("halt_flag", 32'(o_halt), 32'd1);
    check("halt_addr", 32'(o_Addr), 32'd3);
    check("halt_count", 32'(o_instr_count), 32'd3);
    repeat (10) cycle(1'b1, 1'($urandom_range(0, 1)));
    check("halt_sticky", 32'(o_halt), 32'd1);
    check("halt_addr_held", 32'(o_Addr), 32'd3);
    check("halt_count_held", 32'(o_instr_count), 32'd3);

    // Pause: enable drops during the second fetch.
    for (int i = 0; i < 8; i++) mem[i] = rand_nonhalt();
    do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("pause_addr", 32'(o_Addr), 32'd2);
    check("pause_count", 32'(o_instr_count), 32'd2);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b1, 1'b1);

    // NOP opcode 11010 at address 0.
    mem[0] = {5'b11010, 11'($urandom)};
    do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("nop_addr", 32'(o_Addr), 32'd1);
    check("nop_count", 32'(o_instr_count), 32'd1);

    // Asynchronous reset in the middle of a SUB execute cycle.
    mem[0] = {5'd6, 11'h123};
    do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    check("sub_rdram", 32'(o_RdRam), 32'd1);
    i_reset = 1'b0;
    #1;
    check("async_rst_rdram", 32'(o_RdRam), 32'd0);
    check("async_rst_wracc", 32'(o_WrAcc), 32'd0);
    check("async_rst_addr", 32'(o_Addr), 32'd0);
    check("async_rst_operand", 32'(o_Operand), 32'd0);
    cycle(1'b0, 1'b0);

    // Long random run through PC wrap at 0x7FF (a NOP sits there).
    for (int i = 0; i < 2048; i++) mem[i] = rand_nonhalt();
    mem[11'h7FF] = {5'b01000, 11'($urandom)};
    do_reset();
    repeat (5200) cycle(1'b1, 1'($urandom_range(0, 9) != 0));

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
